// File: rtl/sys_clk_timer_sequencer_if.sv
// Command, status and timer-slave signals of the interval timer sequencer.
// slave : the sequencer itself (takes commands, masters the timer slave port).
// master: the environment (requester plus the timer slave it drives).
interface sys_clk_timer_sequencer_if #(
    parameter int unsigned TICK_CNT_W = 16
) ();
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [31:0]           cmd_period;
    logic                  busy;
    logic                  timer_active;
    logic [31:0]           cur_period;
    logic                  tick;
    logic [TICK_CNT_W-1:0] tick_count;
    logic                  snap_valid;
    logic [31:0]           snap_value;
    logic [2:0]            tmr_address;
    logic                  tmr_chipselect;
    logic                  tmr_write_n;
    logic [15:0]           tmr_writedata;
    logic [15:0]           tmr_readdata;
    logic                  tmr_irq;

    modport slave (
        input  cmd_valid, cmd_op, cmd_period, tmr_readdata, tmr_irq,
        output cmd_ready, busy, timer_active, cur_period, tick, tick_count,
        output snap_valid, snap_value,
        output tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata
    );

    modport master (
        output cmd_valid, cmd_op, cmd_period, tmr_readdata, tmr_irq,
        input  cmd_ready, busy, timer_active, cur_period, tick, tick_count,
        input  snap_valid, snap_value,
        input  tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata
    );
endinterface

// File: rtl/sys_clk_timer_sequencer.sv
// Interval timer sequencer: sole master of the timer's 16-bit Avalon-MM slave.
// Expands single-beat commands into register write sequences, clears status on
// IRQ and reports ticks. Optional macro TIMER_SEQ_SNAPSHOT_EN builds the
// snapshot read path; without it op 11 is accepted and ignored.
module sys_clk_timer_sequencer #(
    parameter int unsigned TICK_CNT_W   = 16,
    parameter logic [31:0] RESET_PERIOD = 32'd49999
) (
    input logic                      clk,
    input logic                      reset_n,
    sys_clk_timer_sequencer_if.slave bus
);
    localparam logic [3:0] StIdle     = 4'd0;
    localparam logic [3:0] StWrPl     = 4'd1;
    localparam logic [3:0] StWrPh     = 4'd2;
    localparam logic [3:0] StWrCtrl   = 4'd3;
    localparam logic [3:0] StClrSt    = 4'd4;
    localparam logic [3:0] StSnapWr   = 4'd5;
    localparam logic [3:0] StSnapRl   = 4'd6;
    localparam logic [3:0] StSnapRh   = 4'd7;
    localparam logic [3:0] StSnapDone = 4'd8;

    localparam logic [1:0] OpOneShot = 2'b00;
    localparam logic [1:0] OpCont    = 2'b01;
    localparam logic [1:0] OpStop    = 2'b10;

    logic [3:0]            state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [31:0]           period_q, period_d;
    logic                  accept;
    logic                  cmd_ready;
    logic                  cs_q, cs_d, wn_q, wn_d;
    logic [2:0]            addr_q, addr_d;
    logic [15:0]           wdata_q, wdata_d;
    logic                  active_q, cont_q;
    logic [31:0]           cur_period_q;
    logic                  tick_q;
    logic [TICK_CNT_W-1:0] tick_count_q;

    // IRQ service wins over a new command while idle.
    assign cmd_ready = (state_q == StIdle) && !bus.tmr_irq;
    assign accept    = bus.cmd_valid && cmd_ready;
    assign op_d      = accept ? bus.cmd_op : op_q;
    assign period_d  = (accept && !bus.cmd_op[1]) ? bus.cmd_period : period_q;

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (bus.tmr_irq) begin
                    state_d = StClrSt;
                end else if (bus.cmd_valid) begin
                    case (bus.cmd_op)
                        OpOneShot, OpCont: state_d = StWrPl;
                        OpStop:            state_d = StWrCtrl;
`ifdef TIMER_SEQ_SNAPSHOT_EN
                        default:           state_d = StSnapWr;
`else
                        default:           state_d = StIdle;
`endif
                    endcase
                end
            end
            StWrPl:     state_d = StWrPh;
            StWrPh:     state_d = StWrCtrl;
            StWrCtrl:   state_d = StIdle;
            StClrSt:    state_d = StIdle;
`ifdef TIMER_SEQ_SNAPSHOT_EN
            StSnapWr:   state_d = StSnapRl;
            StSnapRl:   state_d = StSnapRh;
            StSnapRh:   state_d = StSnapDone;
            StSnapDone: state_d = StIdle;
`endif
            default:    state_d = StIdle;
        endcase
    end

    // Bus outputs are registered from the next state so each beat lines up with its state.
    always_comb begin
        cs_d    = 1'b0;
        wn_d    = 1'b1;
        addr_d  = 3'd0;
        wdata_d = 16'h0000;
        case (state_d)
            StWrPl: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd2; wdata_d = period_d[15:0];
            end
            StWrPh: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd3; wdata_d = period_d[31:16];
            end
            StWrCtrl: begin
                cs_d   = 1'b1;
                wn_d   = 1'b0;
                addr_d = 3'd1;
                if (op_d == OpStop)      wdata_d = 16'h0008;
                else if (op_d == OpCont) wdata_d = 16'h0007;
                else                     wdata_d = 16'h0005;
            end
            StClrSt: begin
                cs_d = 1'b1; wn_d = 1'b0;
            end
            StSnapWr: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd4;
            end
            StSnapRl: addr_d = 3'd4;
            StSnapRh: addr_d = 3'd5;
            default: ;
        endcase
    end

    // FSM, latched command and registered bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            op_q     <= OpOneShot;
            period_q <= 32'd0;
            cs_q     <= 1'b0;
            wn_q     <= 1'b1;
            addr_q   <= 3'd0;
            wdata_q  <= 16'h0000;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            period_q <= period_d;
            cs_q     <= cs_d;
            wn_q     <= wn_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Timer status as the sequencer believes it, plus tick reporting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q     <= 1'b0;
            cont_q       <= 1'b0;
            cur_period_q <= RESET_PERIOD;
            tick_q       <= 1'b0;
            tick_count_q <= '0;
        end else begin
            tick_q <= (state_d == StClrSt);
            if (state_d == StWrCtrl) begin
                if (op_d == OpStop) begin
                    active_q <= 1'b0;
                end else begin
                    active_q     <= 1'b1;
                    cont_q       <= op_d[0];
                    cur_period_q <= period_d;
                end
            end
            if (state_d == StClrSt) begin
                tick_count_q <= tick_count_q + TICK_CNT_W'(1);
                if (!cont_q) active_q <= 1'b0;
            end
        end
    end

`ifdef TIMER_SEQ_SNAPSHOT_EN
    logic [15:0] snap_lo_q;
    logic        snap_valid_q;
    logic [31:0] snap_value_q;

    // Read data trails the address by one cycle: low half lands in SnapRh, high in SnapDone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_lo_q    <= 16'h0000;
            snap_valid_q <= 1'b0;
            snap_value_q <= 32'd0;
        end else begin
            snap_valid_q <= (state_q == StSnapDone);
            if (state_q == StSnapRh)   snap_lo_q    <= bus.tmr_readdata;
            if (state_q == StSnapDone) snap_value_q <= {bus.tmr_readdata, snap_lo_q};
        end
    end

    assign bus.snap_valid = snap_valid_q;
    assign bus.snap_value = snap_value_q;
`else
    logic unused_readdata;
    assign unused_readdata = ^bus.tmr_readdata;
    assign bus.snap_valid  = 1'b0;
    assign bus.snap_value  = 32'd0;
`endif

    assign bus.cmd_ready      = cmd_ready;
    assign bus.busy           = (state_q != StIdle);
    assign bus.timer_active   = active_q;
    assign bus.cur_period     = cur_period_q;
    assign bus.tick           = tick_q;
    assign bus.tick_count     = tick_count_q;
    assign bus.tmr_address    = addr_q;
    assign bus.tmr_chipselect = cs_q;
    assign bus.tmr_write_n    = wn_q;
    assign bus.tmr_writedata  = wdata_q;
endmodule

// File: tb/tb_sys_clk_timer_sequencer.sv
// Directed bench for sys_clk_timer_sequencer: command table plus hand-written
// IRQ, priority, snapshot and reset-abort sequences against a small timer model.
module tb_sys_clk_timer_sequencer;
    localparam int HIST = 2048;

    typedef struct {
        logic [1:0]       op;
        logic [31:0]      period;
        int               n_wr;
        logic [2:0][18:0] wr;
        logic             exp_active;
        logic [31:0]      exp_cur;
    } vec_t;

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    sys_clk_timer_sequencer_if #(.TICK_CNT_W(16)) ifc ();

    sys_clk_timer_sequencer #(
        .TICK_CNT_W  (16),
        .RESET_PERIOD(32'd49999)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (ifc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Timer slave model: registered readdata, snapshot on write to 4, IRQ cleared by status write.
    logic        irq_req = 1'b0;
    logic        irq_q = 1'b0;
    logic [15:0] rdata_q = 16'h0000;
    logic [31:0] snap_q = 32'd0;
    logic [31:0] tmr_counter = 32'h0002_1234;
    assign ifc.tmr_irq      = irq_q;
    assign ifc.tmr_readdata = rdata_q;

    always @(posedge clk) begin
        if (ifc.tmr_chipselect && !ifc.tmr_write_n && ifc.tmr_address == 3'd0) irq_q <= 1'b0;
        if (irq_req) irq_q <= 1'b1;
        if (ifc.tmr_chipselect && !ifc.tmr_write_n && ifc.tmr_address == 3'd4)
            snap_q <= tmr_counter;
        if (ifc.tmr_address == 3'd4)      rdata_q <= snap_q[15:0];
        else if (ifc.tmr_address == 3'd5) rdata_q <= snap_q[31:16];
        else                              rdata_q <= 16'h0000;
    end

    // Bus monitor.
    wr_t        wlog[$];
    logic [2:0] addr_hist[HIST];
    logic       cs_hist[HIST];
    int         tick_seen = 0;
    int         snap_seen = 0;
    int         snap_cyc = -1;
    int         busy_seen = 0;

    always @(negedge clk) begin
        if (cyc < HIST) begin
            addr_hist[cyc] = ifc.tmr_address;
            cs_hist[cyc]   = ifc.tmr_chipselect;
        end
        if (ifc.tmr_chipselect && !ifc.tmr_write_n)
            wlog.push_back('{ifc.tmr_address, ifc.tmr_writedata, cyc});
        if (ifc.tick) tick_seen++;
        if (ifc.snap_valid) begin
            snap_seen++;
            snap_cyc = cyc;
        end
        if (ifc.busy) busy_seen++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [18:0] w(input logic [2:0] a, input logic [15:0] d);
        return {a, d};
    endfunction

    function automatic vec_t mkv(input logic [1:0] op, input logic [31:0] per, input int n,
                                 input logic [18:0] w0, input logic [18:0] w1,
                                 input logic [18:0] w2, input logic act,
                                 input logic [31:0] cur);
        vec_t v;
        v.op = op; v.period = per; v.n_wr = n;
        v.wr = {w2, w1, w0};
        v.exp_active = act; v.exp_cur = cur;
        return v;
    endfunction

    function automatic logic [31:0] wlog_entry(input int idx);
        if (idx < 0 || idx >= wlog.size()) return 32'hFFFF_FFFF;
        return {13'd0, wlog[idx].addr, wlog[idx].data};
    endfunction

    function automatic int wlog_cyc(input int idx);
        if (idx < 0 || idx >= wlog.size()) return -1;
        return wlog[idx].cyc;
    endfunction

    // cmd_valid is already high; wait (bounded) for the accepting edge.
    task automatic wait_accept(output int acc);
        acc = -1;
        for (int k = 0; k < 20; k++) begin
            if (ifc.cmd_ready) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got cmd_ready=0, want 1 within 20 cycles");
        end
        @(negedge clk);
        ifc.cmd_valid = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] per, output int acc);
        @(negedge clk);
        ifc.cmd_valid  = 1'b1;
        ifc.cmd_op     = op;
        ifc.cmd_period = per;
        wait_accept(acc);
    endtask

    task automatic pulse_irq();
        @(negedge clk);
        irq_req = 1'b1;
        @(negedge clk);
        irq_req = 1'b0;
    endtask

    vec_t vt[7];

    initial begin
        int acc, base, t0, s0, b0;
        ifc.cmd_valid  = 1'b0;
        ifc.cmd_op     = 2'b00;
        ifc.cmd_period = 32'd0;

        vt[0] = mkv(2'b01, 32'h0001_86A0, 3, w(2, 16'h86A0), w(3, 16'h0001), w(1, 16'h0007),
                    1'b1, 32'h0001_86A0);
        vt[1] = mkv(2'b10, 32'h0000_0000, 1, w(1, 16'h0008), 19'd0, 19'd0, 1'b0, 32'h0001_86A0);
        vt[2] = mkv(2'b10, 32'h1111_1111, 1, w(1, 16'h0008), 19'd0, 19'd0, 1'b0, 32'h0001_86A0);
        vt[3] = mkv(2'b00, 32'd10, 3, w(2, 16'h000A), w(3, 16'h0000), w(1, 16'h0005),
                    1'b1, 32'd10);
        vt[4] = mkv(2'b00, 32'hDEAD_BEEF, 3, w(2, 16'hBEEF), w(3, 16'hDEAD), w(1, 16'h0005),
                    1'b1, 32'hDEAD_BEEF);
        vt[5] = mkv(2'b01, 32'd0, 3, w(2, 16'h0000), w(3, 16'h0000), w(1, 16'h0007),
                    1'b1, 32'd0);
        vt[6] = mkv(2'b10, 32'hFFFF_FFFF, 1, w(1, 16'h0008), 19'd0, 19'd0, 1'b0, 32'd0);

        // Reset then idle.
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_busy", {31'd0, ifc.busy}, 32'd0);
        chk("rst_active", {31'd0, ifc.timer_active}, 32'd0);
        chk("rst_cur_period", ifc.cur_period, 32'd49999);
        chk("rst_tick", {31'd0, ifc.tick}, 32'd0);
        chk("rst_tick_count", {16'd0, ifc.tick_count}, 32'd0);
        chk("rst_snap", {31'd0, ifc.snap_valid}, 32'd0);
        chk("rst_snap_value", ifc.snap_value, 32'd0);
        chk("rst_bus", {11'd0, ifc.tmr_chipselect, ifc.tmr_write_n, ifc.tmr_address,
                        ifc.tmr_writedata}, {11'd0, 1'b0, 1'b1, 3'd0, 16'h0000});
        chk("rst_no_writes", wlog.size(), 32'd0);
        chk("rst_cmd_ready", {31'd0, ifc.cmd_ready}, 32'd1);

        // Continuous timer, two IRQs.
        issue(2'b01, 32'h0001_86A0, acc);
        repeat (4) @(negedge clk);
        base = wlog.size();
        t0   = tick_seen;
        pulse_irq();
        repeat (4) @(negedge clk);
        pulse_irq();
        repeat (4) @(negedge clk);
        chk("cont_irq_nwr", wlog.size() - base, 32'd2);
        chk("cont_irq_wr0", wlog_entry(base), {13'd0, w(0, 16'h0000)});
        chk("cont_irq_wr1", wlog_entry(base + 1), {13'd0, w(0, 16'h0000)});
        chk("cont_irq_ticks", tick_seen - t0, 32'd2);
        chk("cont_irq_tick_count", {16'd0, ifc.tick_count}, 32'd2);
        chk("cont_irq_active", {31'd0, ifc.timer_active}, 32'd1);

        // Command table.
        for (int v = 0; v < 7; v++) begin
            base = wlog.size();
            issue(vt[v].op, vt[v].period, acc);
            repeat (5) @(negedge clk);
            chk($sformatf("v%0d_nwr", v), wlog.size() - base, vt[v].n_wr);
            for (int i = 0; i < vt[v].n_wr; i++) begin
                chk($sformatf("v%0d_wr%0d", v, i), wlog_entry(base + i), {13'd0, vt[v].wr[i]});
                chk($sformatf("v%0d_wr%0d_cyc", v, i), wlog_cyc(base + i), acc + 1 + i);
            end
            chk($sformatf("v%0d_active", v), {31'd0, ifc.timer_active}, {31'd0, vt[v].exp_active});
            chk($sformatf("v%0d_cur", v), ifc.cur_period, vt[v].exp_cur);
            chk($sformatf("v%0d_busy", v), {31'd0, ifc.busy}, 32'd0);
        end

        // One-shot: IRQ clears status and stops; then stop op.
        issue(2'b00, 32'd10, acc);
        repeat (5) @(negedge clk);
        base = wlog.size();
        pulse_irq();
        repeat (4) @(negedge clk);
        chk("oneshot_nwr", wlog.size() - base, 32'd1);
        chk("oneshot_wr", wlog_entry(base), {13'd0, w(0, 16'h0000)});
        chk("oneshot_tick_count", {16'd0, ifc.tick_count}, 32'd3);
        chk("oneshot_active", {31'd0, ifc.timer_active}, 32'd0);
        base = wlog.size();
        issue(2'b10, 32'd0, acc);
        repeat (4) @(negedge clk);
        chk("stop_nwr", wlog.size() - base, 32'd1);
        chk("stop_wr", wlog_entry(base), {13'd0, w(1, 16'h0008)});

        // IRQ concurrent with a command: status clear first.
        issue(2'b01, 32'h0000_0055, acc);
        repeat (5) @(negedge clk);
        base = wlog.size();
        @(negedge clk);
        irq_req = 1'b1;
        @(negedge clk);
        irq_req        = 1'b0;
        ifc.cmd_valid  = 1'b1;
        ifc.cmd_op     = 2'b10;
        ifc.cmd_period = 32'd0;
        chk("prio_ready_low", {31'd0, ifc.cmd_ready}, 32'd0);
        wait_accept(acc);
        repeat (4) @(negedge clk);
        chk("prio_nwr", wlog.size() - base, 32'd2);
        chk("prio_wr0", wlog_entry(base), {13'd0, w(0, 16'h0000)});
        chk("prio_wr1", wlog_entry(base + 1), {13'd0, w(1, 16'h0008)});
        chk("prio_accept_cyc", acc, wlog_cyc(base) + 1);
        chk("prio_stop_cyc", wlog_cyc(base + 1), wlog_cyc(base) + 2);
        chk("prio_tick_count", {16'd0, ifc.tick_count}, 32'd4);
        chk("prio_active", {31'd0, ifc.timer_active}, 32'd0);

        // Snapshot.
        base = wlog.size();
        s0   = snap_seen;
        b0   = busy_seen;
        issue(2'b11, 32'd0, acc);
        repeat (8) @(negedge clk);
`ifdef TIMER_SEQ_SNAPSHOT_EN
        chk("snap_nwr", wlog.size() - base, 32'd1);
        chk("snap_wr", wlog_entry(base), {13'd0, w(4, 16'h0000)});
        chk("snap_wr_cyc", wlog_cyc(base), acc + 1);
        if (acc >= 0 && acc + 3 < HIST) begin
            chk("snap_rd_lo", {28'd0, cs_hist[acc + 2], addr_hist[acc + 2]}, {28'd0, 1'b0, 3'd4});
            chk("snap_rd_hi", {28'd0, cs_hist[acc + 3], addr_hist[acc + 3]}, {28'd0, 1'b0, 3'd5});
        end
        chk("snap_pulses", snap_seen - s0, 32'd1);
        chk("snap_valid_cyc", snap_cyc, acc + 5);
        chk("snap_value", ifc.snap_value, 32'h0002_1234);
`else
        chk("nosnap_nwr", wlog.size() - base, 32'd0);
        chk("nosnap_pulses", snap_seen - s0, 32'd0);
        chk("nosnap_value", ifc.snap_value, 32'd0);
        chk("nosnap_busy", busy_seen - b0, 32'd0);
`endif
        chk("snap_ready_after", {31'd0, ifc.cmd_ready}, 32'd1);

        // Reset in the middle of a start sequence aborts it.
        base = wlog.size();
        issue(2'b01, 32'h1234_5678, acc);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_bus", {11'd0, ifc.tmr_chipselect, ifc.tmr_write_n, ifc.tmr_address,
                          ifc.tmr_writedata}, {11'd0, 1'b0, 1'b1, 3'd0, 16'h0000});
        chk("abort_busy", {31'd0, ifc.busy}, 32'd0);
        chk("abort_cur", ifc.cur_period, 32'd49999);
        chk("abort_tick_count", {16'd0, ifc.tick_count}, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_nwr", wlog.size() - base, 32'd1);
        chk("abort_wr0", wlog_entry(base), {13'd0, w(2, 16'h5678)});
        chk("abort_active", {31'd0, ifc.timer_active}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sys_clk_timer_sequencer.md
Name: sys_clk_timer_sequencer

Overview:
Sequencer that owns the 16-bit Avalon-MM slave port of the system interval timer. It turns single-beat commands from a requester (start one-shot, start continuous, stop, snapshot) into the timer's multi-write register sequences. It services the timer IRQ by clearing status, and reports ticks and 32-bit snapshots upstream. It sits between a CPU-side or hardware requester and the timer slave, and is the only master of that slave.

Parameters:
TICK_CNT_W, 16, width of the tick counter (wraps).
RESET_PERIOD, 49999, value reported on cur_period after reset (matches the timer reset period).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  2  00 start one-shot, 01 start continuous, 10 stop, 11 snapshot
cmd_period  in  32  period for start ops (ignored otherwise)
busy  out  1  FSM not IDLE
timer_active  out  1  sequencer believes timer is counting
cur_period  out  32  last period programmed
tick  out  1  one-cycle pulse per serviced timeout
tick_count  out  TICK_CNT_W  serviced timeouts, wraps
snap_valid  out  1  one-cycle pulse, snap_value valid
snap_value  out  32  captured counter snapshot
tmr_address  out  3  timer slave address
tmr_chipselect  out  1  timer chipselect
tmr_write_n  out  1  timer write strobe, active low
tmr_writedata  out  16  timer write data
tmr_readdata  in  16  timer read data, registered: valid 1 cycle after address
tmr_irq  in  1  timer interrupt, level

Behaviour:
- One clock domain (clk). reset_n is asynchronous, active-low.
- Reset values:
  - FSM in IDLE, busy=0, timer_active=0, cur_period=RESET_PERIOD.
  - tick=0, tick_count=0, snap_valid=0, snap_value=0.
  - tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0.
- All tmr_* outputs are registered. A reset mid-sequence aborts it with no further bus activity.
- Bus idle value: chipselect=0, write_n=1, address=0, writedata=0.
- Each write is exactly one cycle with chipselect=1 and write_n=0.
- cmd_ready = (state==IDLE) && !tmr_irq. IRQ service has priority over a new command in IDLE.
- States: IDLE, WR_PL, WR_PH, WR_CTRL, CLR_ST, SNAP_WR, SNAP_RL, SNAP_RH, SNAP_DONE.
- Start (op 00/01): latch period and op. IRQ is always enabled.
  - WR_PL: addr 2, data period[15:0].
  - WR_PH: addr 3, data period[31:16].
  - WR_CTRL: addr 1, data 0x0005 (one-shot) or 0x0007 (continuous).
  - Then IDLE. timer_active=1 and cur_period=period are set on the WR_CTRL cycle.
  - Command to first write is 1 cycle; 3 bus cycles total.
- Stop (op 10): WR_CTRL addr 1, data 0x0008. timer_active=0 on that cycle.
- IRQ service: in IDLE with tmr_irq=1, go to CLR_ST.
  - CLR_ST: write addr 0, data 0x0000; tick=1; tick_count+1 (wraps from all-ones to 0).
  - If the mode is one-shot, timer_active=0.
  - Return to IDLE. The timer drops irq by the next cycle, so no re-trigger.
- Snapshot (op 11):
  - SNAP_WR: write addr 4, data 0.
  - SNAP_RL: read, address 4, chipselect=0.
  - SNAP_RH: address 5; capture tmr_readdata as the low half.
  - SNAP_DONE: capture the high half; snap_valid=1; snap_value updated.
  - Then IDLE. Command to snap_valid is 5 cycles.
- An IRQ arriving during any sequence is held by the timer and serviced on the first IDLE cycle.
- A stop while already stopped, or a start while running, is legal and reprograms fully.
- A period of 0 is passed through unchanged.

Optional Feature:
TIMER_SEQ_SNAPSHOT_EN:
- Defined: op 11 performs the snapshot sequence above.
- Undefined: op 11 is accepted (one cycle, cmd_ready honoured), produces no bus activity, and returns straight to IDLE. snap_valid stays 0 and snap_value stays 0. SNAP_* states and capture registers are not built.

Test Plan:
- Reset, then idle 5 cycles -> all outputs at reset values, no chipselect, cur_period=49999.
- cmd op=01, period=0x0001_86A0 -> writes (2,0x86A0), (3,0x0001), (1,0x0007) on consecutive cycles; timer_active=1; cur_period=0x000186A0.
- Continuous timer irq rising twice -> two CLR_ST writes (0,0x0000); tick pulses twice; tick_count=2; timer_active stays 1.
- Start one-shot, period=10; irq -> one status clear; tick_count+1; timer_active=0. Stop op -> single write (1,0x0008).
- tmr_irq=1 concurrent with cmd_valid in IDLE -> cmd_ready=0; status clear first, command accepted the cycle after.
- Snapshot with the timer model holding counter 0x0002_1234 -> write (4,0), reads 4 then 5; snap_valid 5 cycles after accept with snap_value=0x00021234. With the macro undefined, no bus activity and no snap_valid.
